// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register IDs and
// the pipeline-control FSM state type.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] SAOK = 2'd0;
  localparam logic [1:0] SHLT = 2'd1;
  localparam logic [1:0] SADR = 2'd2;
  localparam logic [1:0] SINS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Bank of five saturating performance counters with per-counter increment
// enables and a synchronous clear.
module pipe_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [4:0]       i_inc,
  output logic [CNT_W-1:0] o_cyc,
  output logic [CNT_W-1:0] o_ret,
  output logic [CNT_W-1:0] o_lu,
  output logic [CNT_W-1:0] o_mp,
  output logic [CNT_W-1:0] o_rt
);

  logic [CNT_W-1:0] r_cnt [5];

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 5; i++) begin
      if (i_clr)
        r_cnt[i] <= '0;
      else if (i_inc[i] && (r_cnt[i] != '1))
        r_cnt[i] <= r_cnt[i] + 1'b1;
    end
  end

  assign o_cyc = r_cnt[0];
  assign o_ret = r_cnt[1];
  assign o_lu  = r_cnt[2];
  assign o_mp  = r_cnt[3];
  assign o_rt  = r_cnt[4];

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble/CC-enable generation, post-reset flush
// and stop-on-exception. Counter bank present only with PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic             running,
  output logic             halted,
  output logic [1:0]       stop_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] rt_cnt
);

  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  ctrl_state_t   r_state, w_state_nxt;
  logic [FW-1:0] r_flush_cnt, w_flush_cnt_nxt;
  logic [1:0]    r_stop_stat;

  logic w_lu, w_rt, w_mp, w_mx, w_wx;

  assign w_lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign w_mp = (E_icode == IJXX) && !e_cnd;
  assign w_mx = (m_stat != SAOK);
  assign w_wx = (W_stat != SAOK);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FLUSH;
      r_flush_cnt <= '0;
      r_stop_stat <= SAOK;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      if ((r_state == RUN) && w_wx)
        r_stop_stat <= W_stat;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    unique case (r_state)
      FLUSH: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (r_flush_cnt == FLUSH_LAST)
          w_state_nxt = RUN;
        else
          w_flush_cnt_nxt = r_flush_cnt + 1'b1;
      end
      RUN: begin
        F_stall  = w_lu | w_rt;
        D_stall  = w_lu;
        // a load-use stall holds D, so it must not also be bubbled for ret
        D_bubble = w_mp | (w_rt & !w_lu);
        E_bubble = w_mp | w_lu;
        set_cc   = (E_icode == IOPQ) & !w_mx & !w_wx;
        M_bubble = w_mx | w_wx;
        W_stall  = w_wx;
        if (w_wx)
          w_state_nxt = STOP;
      end
      STOP: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: w_state_nxt = FLUSH;
    endcase
  end

  assign running   = (r_state == RUN);
  assign halted    = (r_state == STOP);
  assign stop_stat = r_stop_stat;

`ifdef PIPE_CTRL_PERF_EN
  logic [4:0] w_inc;
  logic       w_ret;

  assign w_ret = (W_stat == SAOK) && (W_icode != INOP) && (W_icode != IHALT);
  assign w_inc = running ? {w_rt & !w_lu, w_mp, w_lu, w_ret, 1'b1} : 5'b0;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .i_clk (clk),
    .i_clr (!rst_n),
    .i_inc (w_inc),
    .o_cyc (cyc_cnt),
    .o_ret (ret_cnt),
    .o_lu  (lu_cnt),
    .o_mp  (mp_cnt),
    .o_rt  (rt_cnt)
  );
`else
  logic w_unused_icode;
  assign w_unused_icode = ^W_icode;

  assign cyc_cnt = '0;
  assign ret_cnt = '0;
  assign lu_cnt  = '0;
  assign mp_cnt  = '0;
  assign rt_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares them.
module tb_pipe_ctrl;

  localparam int unsigned FC = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic          e_cnd;
  logic [1:0]    m_stat, W_stat;
  logic          F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
  logic          set_cc, running, halted;
  logic [1:0]    stop_stat;
  logic [CW-1:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rt_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .set_cc(set_cc), .running(running), .halted(halted), .stop_stat(stop_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt),
    .mp_cnt(mp_cnt), .rt_cnt(rt_cnt)
  );

  // ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, running, halted}
  localparam logic [8:0] C_FL   = 9'b1_0_1_1_1_0_0_0_0;
  localparam logic [8:0] C_IDLE = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_LU   = 9'b1_1_0_1_0_0_0_1_0;
  localparam logic [8:0] C_MP   = 9'b0_0_1_1_0_0_0_1_0;
  localparam logic [8:0] C_RT   = 9'b1_0_1_0_0_0_0_1_0;
  localparam logic [8:0] C_MPRT = 9'b1_0_1_1_0_0_0_1_0;
  localparam logic [8:0] C_CC   = 9'b0_0_0_0_0_0_1_1_0;
  localparam logic [8:0] C_MX   = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] C_WX   = 9'b0_0_0_0_1_1_0_1_0;
  localparam logic [8:0] C_STOP = 9'b1_0_1_1_1_1_0_0_1;

  typedef struct {
    string         name;
    logic [8:0]    ctl;
    logic [1:0]    st;
    logic [CW-1:0] cnt [5];
  } exp_t;

  exp_t sb_q [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [CW-1:0] m_cnt [5];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    if (en && (v != {CW{1'b1}})) return v + 1'b1;
    return v;
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = 2'd0; W_stat = 2'd0;
  endtask

  // Push the expectation for the current cycle, then advance the counter
  // model by what this cycle's edge should add.
  task automatic expect_cyc(input string name, input logic [8:0] ctl, input logic [1:0] st,
                            input logic i_ret, input logic i_lu, input logic i_mp, input logic i_rt);
    exp_t e;
    e.name = name;
    e.ctl  = ctl;
    e.st   = st;
    for (int i = 0; i < 5; i++) e.cnt[i] = m_cnt[i];
    sb_q.push_back(e);
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = '0;
    end else if (ctl[1]) begin
      m_cnt[0] = sat_inc(m_cnt[0], 1'b1);
      m_cnt[1] = sat_inc(m_cnt[1], i_ret);
      m_cnt[2] = sat_inc(m_cnt[2], i_lu);
      m_cnt[3] = sat_inc(m_cnt[3], i_mp);
      m_cnt[4] = sat_inc(m_cnt[4], i_rt);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [8:0]    a_ctl;
      logic [CW-1:0] a_cnt [5];
      logic [CW-1:0] r_cnt [5];
      e = sb_q.pop_front();
      a_ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, running, halted};
      a_cnt[0] = cyc_cnt; a_cnt[1] = ret_cnt; a_cnt[2] = lu_cnt;
      a_cnt[3] = mp_cnt;  a_cnt[4] = rt_cnt;
      for (int i = 0; i < 5; i++) begin
`ifdef PIPE_CTRL_PERF_EN
        r_cnt[i] = e.cnt[i];
`else
        r_cnt[i] = '0;
`endif
      end
      n_cmp++;
      if (a_ctl !== e.ctl) begin
        n_fail++;
        $display("FAIL %s ctl: got %b want %b", e.name, a_ctl, e.ctl);
      end
      n_cmp++;
      if (stop_stat !== e.st) begin
        n_fail++;
        $display("FAIL %s stop_stat: got %0d want %0d", e.name, stop_stat, e.st);
      end
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (a_cnt[i] !== r_cnt[i]) begin
          n_fail++;
          $display("FAIL %s cnt[%0d]: got %0d want %0d", e.name, i, a_cnt[i], r_cnt[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 5; i++) m_cnt[i] = '0;
    rst_n = 1'b0;
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_cnd = 1'b1;
    m_stat = 2'd0; W_stat = 2'd0;

    // reset held two edges, then flush for FC cycles
    nxt(); rst_n = 1'b0; expect_cyc("rst_a", C_FL, 2'd0, 0, 0, 0, 0);
    nxt(); rst_n = 1'b0; expect_cyc("rst_b", C_FL, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      nxt(); rst_n = 1'b1; expect_cyc("flush", C_FL, 2'd0, 0, 0, 0, 0);
    end
    nxt(); expect_cyc("run0", C_IDLE, 2'd0, 0, 0, 0, 0);

    nxt(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    expect_cyc("lu_mrm", C_LU, 2'd0, 0, 1, 0, 0);
    nxt(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    expect_cyc("lu_pop", C_LU, 2'd0, 0, 1, 0, 0);
    nxt(); E_icode = 4'h5; E_dstM = 4'hF;
    expect_cyc("lu_rnone", C_IDLE, 2'd0, 0, 0, 0, 0);
    nxt(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h4; d_srcB = 4'h2;
    expect_cyc("lu_nomatch", C_IDLE, 2'd0, 0, 0, 0, 0);

    nxt(); E_icode = 4'h7; e_cnd = 1'b0;
    expect_cyc("mp", C_MP, 2'd0, 0, 0, 1, 0);
    nxt(); E_icode = 4'h7; e_cnd = 1'b1;
    expect_cyc("mp_taken", C_IDLE, 2'd0, 0, 0, 0, 0);

    nxt(); D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    expect_cyc("rt_lu", C_LU, 2'd0, 0, 1, 0, 0);
    nxt(); D_icode = 4'h9; expect_cyc("rt_d", C_RT, 2'd0, 0, 0, 0, 1);
    nxt(); E_icode = 4'h9; expect_cyc("rt_e", C_RT, 2'd0, 0, 0, 0, 1);
    nxt(); M_icode = 4'h9; expect_cyc("rt_m", C_RT, 2'd0, 0, 0, 0, 1);
    nxt(); D_icode = 4'h9; E_icode = 4'h7; e_cnd = 1'b0;
    expect_cyc("mp_rt", C_MPRT, 2'd0, 0, 0, 1, 1);

    nxt(); E_icode = 4'h6; expect_cyc("setcc", C_CC, 2'd0, 0, 0, 0, 0);
    nxt(); W_icode = 4'h6; expect_cyc("ret_op", C_IDLE, 2'd0, 1, 0, 0, 0);
    nxt(); W_icode = 4'h0; expect_cyc("ret_halt", C_IDLE, 2'd0, 0, 0, 0, 0);
    nxt(); W_icode = 4'h2; expect_cyc("ret_rr", C_IDLE, 2'd0, 1, 0, 0, 0);

    nxt(); E_icode = 4'h6; m_stat = 2'd2;
    expect_cyc("mx", C_MX, 2'd0, 0, 0, 0, 0);
    nxt(); E_icode = 4'h6; W_icode = 4'h5; W_stat = 2'd2;
    expect_cyc("wx", C_WX, 2'd0, 0, 0, 0, 0);
    nxt(); E_icode = 4'h7; e_cnd = 1'b0;
    expect_cyc("stop_a", C_STOP, 2'd2, 0, 0, 0, 0);
    nxt(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; W_icode = 4'h6;
    expect_cyc("stop_b", C_STOP, 2'd2, 0, 0, 0, 0);
    nxt(); rst_n = 1'b0; expect_cyc("stop_rst", C_STOP, 2'd2, 0, 0, 0, 0);

    nxt(); rst_n = 1'b1; expect_cyc("reflush0", C_FL, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      nxt(); expect_cyc("reflush", C_FL, 2'd0, 0, 0, 0, 0);
    end
    for (int k = 0; k < 20; k++) begin
      nxt(); W_icode = 4'h6; expect_cyc("sat", C_IDLE, 2'd0, 1, 0, 0, 0);
    end
    nxt(); rst_n = 1'b0; expect_cyc("run_rst", C_IDLE, 2'd0, 0, 0, 0, 0);
    nxt(); rst_n = 1'b1; expect_cyc("post_rst", C_FL, 2'd0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
